// File: rtl/aesl_deadlock_monitor.sv
// aesl_deadlock_monitor
//   Deadlock monitor for a dataflow region of PROC_NUM processes. Each process
//   has a stall counter that filters transient blocking. When any process has
//   been blocked for STALL_THRESH consecutive cycles, the wait-for matrix is
//   snapshotted and every dependence cycle is walked, one record per visited
//   process, over a valid/ready report port.
//
//   Optional feature: define DL_TIMESTAMP_EN to add a free-running cycle
//   counter whose value at the snapshot edge is reported in rpt_time.
//   Without it rpt_time is tied to 0.
//
// Ports
//   clock, reset   rising-edge clock, asynchronous active-low reset
//   block_vec      bit i = process i blocked this cycle
//   wait_for       bit i*PROC_NUM+j = process i waits on process j
//   dl_detect_out  sticky, deadlock confirmed
//   rpt_*          report record stream (valid/ready)
//   token_clear    1-cycle pulse when the last record of a cycle is accepted
//   report_done    sticky, every stalled process reported
//   dbg_state      current FSM state (0 idle, 1 seek, 2 emit, 3 done)
//
// Handshake: a record transfers on a rising edge where rpt_valid and
// rpt_ready are both 1. Once rpt_valid is raised it stays high and every
// rpt_* field stays stable until that transfer happens.
module aesl_deadlock_monitor #(
    parameter int PROC_NUM      = 4,
    parameter int STALL_THRESH  = 64,
    parameter int MAX_CYCLE_LEN = PROC_NUM,
    parameter int TS_W          = 32,
    localparam int IDX_W = ($clog2(PROC_NUM) > 1) ? $clog2(PROC_NUM) : 1,
    localparam int ID_W  = IDX_W + 1,
    localparam int CNT_W = $clog2(STALL_THRESH + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [PROC_NUM-1:0]          block_vec,
    input  logic [PROC_NUM*PROC_NUM-1:0] wait_for,
    output logic                         dl_detect_out,
    output logic                         rpt_valid,
    input  logic                         rpt_ready,
    output logic [ID_W-1:0]              rpt_cycle_id,
    output logic [IDX_W-1:0]             rpt_step,
    output logic [IDX_W-1:0]             rpt_proc,
    output logic [1:0]                   rpt_term,
    output logic [TS_W-1:0]              rpt_time,
    output logic                         token_clear,
    output logic                         report_done,
    output logic [1:0]                   dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEEK = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q [PROC_NUM];
    logic [CNT_W-1:0]    cnt_d [PROC_NUM];
    logic [PROC_NUM-1:0] wf_q  [PROC_NUM];
    logic [PROC_NUM-1:0] wf_d  [PROC_NUM];
    logic [PROC_NUM-1:0] det_q, det_d, done_q, done_d, visit_q, visit_d;
    logic [ID_W-1:0]     cycle_id_q, cycle_id_d;
    logic [IDX_W-1:0]    cur_q, cur_d, origin_q, origin_d, step_q, step_d;

    logic [PROC_NUM-1:0] stalled;
    logic                snap;
    logic                seek_found;
    logic [IDX_W-1:0]    seek_idx;
    logic [PROC_NUM-1:0] succ_row;
    logic                next_found;
    logic [IDX_W-1:0]    next_idx;
    logic [PROC_NUM-1:0] seen;
    logic [1:0]          term;
    logic                accept;

    // Stall counters run in every state; only IDLE looks at them.
    always_comb begin
        for (int i = 0; i < PROC_NUM; i++) begin
            stalled[i] = (cnt_q[i] == CNT_W'(STALL_THRESH));
            if (!block_vec[i])   cnt_d[i] = '0;
            else if (stalled[i]) cnt_d[i] = cnt_q[i];
            else                 cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    assign snap = (state_q == ST_IDLE) && (|stalled);

    // Lowest-index searches: iterate downwards so the lowest hit wins.
    always_comb begin
        seek_found = 1'b0;
        seek_idx   = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (det_q[i] && !done_q[i]) begin
                seek_found = 1'b1;
                seek_idx   = IDX_W'(i);
            end
        end
        succ_row   = wf_q[cur_q];
        next_found = 1'b0;
        next_idx   = '0;
        for (int j = PROC_NUM - 1; j >= 0; j--) begin
            if (succ_row[j]) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(j);
            end
        end
    end

    // The process being reported counts as already visited, so a self-loop
    // off the origin terminates as a merge instead of repeating the process.
    always_comb begin
        seen = done_q | visit_q | (PROC_NUM'(1) << cur_q);
        if (next_found && (next_idx == origin_q))                      term = 2'd1;
        else if (next_found && seen[next_idx])                         term = 2'd2;
        else if (!next_found || (int'(step_q) == MAX_CYCLE_LEN - 1))   term = 2'd3;
        else                                                           term = 2'd0;
    end

    assign accept = (state_q == ST_EMIT) && rpt_ready;

    always_comb begin
        state_d    = state_q;
        det_d      = det_q;
        wf_d       = wf_q;
        done_d     = done_q;
        visit_d    = visit_q;
        cycle_id_d = cycle_id_q;
        cur_d      = cur_q;
        origin_d   = origin_q;
        step_d     = step_q;
        case (state_q)
            ST_IDLE: begin
                if (snap) begin
                    det_d      = stalled;
                    for (int i = 0; i < PROC_NUM; i++) begin
                        wf_d[i] = wait_for[i*PROC_NUM +: PROC_NUM];
                    end
                    done_d     = '0;
                    visit_d    = '0;
                    cycle_id_d = '0;
                    state_d    = ST_SEEK;
                end
            end
            ST_SEEK: begin
                if (seek_found) begin
                    cur_d    = seek_idx;
                    origin_d = seek_idx;
                    step_d   = '0;
                    state_d  = ST_EMIT;
                end else begin
                    state_d  = ST_DONE;
                end
            end
            ST_EMIT: begin
                if (accept) begin
                    done_d[cur_q]  = 1'b1;
                    visit_d[cur_q] = 1'b1;
                    if (term == 2'd0) begin
                        cur_d  = next_idx;
                        step_d = step_q + 1'b1;
                    end else begin
                        cycle_id_d = cycle_id_q + 1'b1;
                        visit_d    = '0;
                        state_d    = ST_SEEK;
                    end
                end
            end
            default: state_d = ST_DONE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            det_q      <= '0;
            done_q     <= '0;
            visit_q    <= '0;
            cycle_id_q <= '0;
            cur_q      <= '0;
            origin_q   <= '0;
            step_q     <= '0;
            for (int i = 0; i < PROC_NUM; i++) begin
                cnt_q[i] <= '0;
                wf_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            det_q      <= det_d;
            done_q     <= done_d;
            visit_q    <= visit_d;
            cycle_id_q <= cycle_id_d;
            cur_q      <= cur_d;
            origin_q   <= origin_d;
            step_q     <= step_d;
            for (int i = 0; i < PROC_NUM; i++) begin
                cnt_q[i] <= cnt_d[i];
                wf_q[i]  <= wf_d[i];
            end
        end
    end

`ifdef DL_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d, time_q, time_d;

    always_comb begin
        ts_d   = ts_q + 1'b1;
        time_d = snap ? ts_q : time_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_q   <= '0;
            time_q <= '0;
        end else begin
            ts_q   <= ts_d;
            time_q <= time_d;
        end
    end

    assign rpt_time = time_q;
`else
    assign rpt_time = '0;
`endif

    assign dl_detect_out = |det_q;
    assign rpt_valid     = (state_q == ST_EMIT);
    assign rpt_cycle_id  = cycle_id_q;
    assign rpt_step      = step_q;
    assign rpt_proc      = cur_q;
    assign rpt_term      = rpt_valid ? term : 2'd0;
    assign token_clear   = accept && (term != 2'd0);
    assign report_done   = (state_q == ST_DONE);
    assign dbg_state     = state_q;

endmodule
